// File: rtl/operand_fetch.sv
// operand_fetch
//
// Operand-fetch stage between instruction decode and execute. Accepts a
// decoded instruction, drives the register-file read addresses in the same
// cycle, waits out the one-cycle BRAM read latency, and then presents the
// 16-bit A operand and the 8-bit B operand to execute.
//
// Ports
//   clk, reset              clock; synchronous active-low reset
//   in_valid/in_ready       decode handshake
//   in_op, in_d             opcode word / destination index (passed through)
//   in_a, in_word, in_b     A source index, A-is-register-pair flag, B source
//   rf_a, rf_b              regfile read addresses (combinational from in_a/in_b)
//   rf_Ra, rf_Rb            regfile read data, one cycle after address
//   wb_write, wb_word       writeback strobe / word-write flag
//   wb_d, wb_Rd             writeback destination index / data
//   out_valid/out_ready     execute handshake
//   out_op, out_d           passed-through opcode / destination
//   out_Ra, out_Rb          A operand (16 bit), B operand (8 bit)
//
// Build option
//   OPFETCH_FWD_EN  when defined, writeback data is forwarded into operands
//                   being loaded or held. When undefined, wb_* is ignored and
//                   decode must space hazards itself.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_op,
  input  logic [5:0]  in_a,
  input  logic        in_word,
  input  logic [5:0]  in_b,
  input  logic [5:0]  in_d,
  output logic [5:0]  rf_a,
  output logic [5:0]  rf_b,
  input  logic [15:0] rf_Ra,
  input  logic [7:0]  rf_Rb,
  input  logic        wb_write,
  input  logic        wb_word,
  input  logic [5:0]  wb_d,
  input  logic [15:0] wb_Rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_op,
  output logic [5:0]  out_d,
  output logic [15:0] out_Ra,
  output logic [7:0]  out_Rb
);

`ifdef OPFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t state_reg, state_next;

  logic        accept;
  logic [15:0] op_reg;
  logic [5:0]  d_reg, a_reg, b_reg;
  logic        word_reg;

  // Writeback seen in the previous cycle. Only consumed in LOAD, where the
  // previous cycle is the accept cycle whose write the BRAM read missed.
  logic        fw_write_reg, fw_word_reg;
  logic [5:0]  fw_d_reg;
  logic [15:0] fw_data_reg;

  logic [15:0] ra_reg;
  logic [7:0]  rb_reg;

  // Byte lanes: 0 = A low, 1 = A high, 2 = B
  logic [2:0][5:0] lane_idx;
  logic [2:0][7:0] lane_rf;
  logic [2:0][7:0] lane_held;
  logic [2:0]      lane_en;
  logic [2:0][7:0] lane_next;

  // Does a write (byte or word) land on register idx?
  function automatic logic wr_hit(input logic wr, input logic wd,
                                  input logic [5:0] d, input logic [5:0] idx);
    wr_hit = wr && (wd ? (d[5:1] == idx[5:1]) : (d == idx));
  endfunction

  // Which byte of the write data lands on register idx.
  function automatic logic [7:0] wr_byte(input logic wd, input logic [15:0] data,
                                         input logic [5:0] idx);
    wr_byte = (wd && idx[0]) ? data[15:8] : data[7:0];
  endfunction

  assign rf_a = in_a;
  assign rf_b = in_b;

  assign accept = in_valid && in_ready;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = LOAD;
      LOAD:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = in_valid ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready = reset;
      HOLD: begin
        in_ready  = reset && out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- instruction latch ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_reg   <= '0;
      d_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      word_reg <= 1'b0;
    end else if (accept) begin
      op_reg   <= in_op;
      d_reg    <= in_d;
      a_reg    <= in_a;
      b_reg    <= in_b;
      // An odd base cannot start a register pair; fall back to a byte read.
      word_reg <= in_word && !in_a[0];
    end
  end

  // ---------------- forward register ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      fw_write_reg <= 1'b0;
      fw_word_reg  <= 1'b0;
      fw_d_reg     <= '0;
      fw_data_reg  <= '0;
    end else begin
      fw_write_reg <= FWD && wb_write;
      fw_word_reg  <= wb_word;
      fw_d_reg     <= wb_d;
      fw_data_reg  <= wb_Rd;
    end
  end

  // ---------------- per-byte operand selection ----------------
  // word_reg implies an even a_reg, so a_reg + 1 never wraps when used.
  assign lane_idx[0]  = a_reg;
  assign lane_idx[1]  = a_reg + 6'd1;
  assign lane_idx[2]  = b_reg;
  assign lane_rf[0]   = rf_Ra[7:0];
  assign lane_rf[1]   = rf_Ra[15:8];
  assign lane_rf[2]   = rf_Rb;
  assign lane_held[0] = ra_reg[7:0];
  assign lane_held[1] = ra_reg[15:8];
  assign lane_held[2] = rb_reg;
  assign lane_en[0]   = 1'b1;
  assign lane_en[1]   = word_reg;
  assign lane_en[2]   = 1'b1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      logic       cur_hit, fw_hit;
      logic [7:0] load_byte, hold_byte;

      assign cur_hit = FWD && lane_en[gi] && wr_hit(wb_write, wb_word, wb_d, lane_idx[gi]);
      assign fw_hit  = FWD && lane_en[gi] && wr_hit(fw_write_reg, fw_word_reg, fw_d_reg, lane_idx[gi]);

      // A write in LOAD is newer than the accept-cycle write, which in turn
      // is newer than what the BRAM returned.
      assign load_byte = !lane_en[gi] ? 8'h00 :
                         cur_hit      ? wr_byte(wb_word, wb_Rd, lane_idx[gi]) :
                         fw_hit       ? wr_byte(fw_word_reg, fw_data_reg, lane_idx[gi]) :
                                        lane_rf[gi];

      assign hold_byte = cur_hit ? wr_byte(wb_word, wb_Rd, lane_idx[gi]) : lane_held[gi];

      assign lane_next[gi] = (state_reg == LOAD) ? load_byte :
                             (state_reg == HOLD) ? hold_byte : lane_held[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      ra_reg <= '0;
      rb_reg <= '0;
    end else begin
      ra_reg <= {lane_next[1], lane_next[0]};
      rb_reg <= lane_next[2];
    end
  end

  assign out_op = op_reg;
  assign out_d  = d_reg;
  assign out_Ra = ra_reg;
  assign out_Rb = rb_reg;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_op;
  logic [5:0]  in_a, in_b, in_d;
  logic        in_word;
  logic [5:0]  rf_a, rf_b;
  logic [15:0] rf_Ra;
  logic [7:0]  rf_Rb;
  logic        wb_write, wb_word;
  logic [5:0]  wb_d;
  logic [15:0] wb_Rd;
  logic        out_valid, out_ready;
  logic [15:0] out_op;
  logic [5:0]  out_d;
  logic [15:0] out_Ra;
  logic [7:0]  out_Rb;

  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_word(in_word), .in_b(in_b), .in_d(in_d),
    .rf_a(rf_a), .rf_b(rf_b), .rf_Ra(rf_Ra), .rf_Rb(rf_Rb),
    .wb_write(wb_write), .wb_word(wb_word), .wb_d(wb_d), .wb_Rd(wb_Rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_d(out_d), .out_Ra(out_Ra), .out_Rb(out_Rb)
  );

  always #5 clk = ~clk;

  // Byte-wide register file, one-cycle read latency, read-old on collision
  logic [7:0] mem [64];
  always @(posedge clk) begin
    rf_Ra <= {mem[6'(rf_a + 6'd1)], mem[rf_a]};
    rf_Rb <= mem[rf_b];
    if (wb_write) begin
      if (wb_word) begin
        mem[{wb_d[5:1], 1'b0}] <= wb_Rd[7:0];
        mem[{wb_d[5:1], 1'b1}] <= wb_Rd[15:8];
      end else begin
        mem[wb_d] <= wb_Rd[7:0];
      end
    end
  end

`ifdef OPFETCH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic wr, input logic wd, input logic [5:0] d, input logic [15:0] data);
    wb_write = wr; wb_word = wd; wb_d = d; wb_Rd = data;
  endtask

  // Accept one instruction (with optional writes in the accept and LOAD
  // cycles) and advance into HOLD.
  task automatic issue(input logic [15:0] op, input logic [5:0] a, input logic w,
                       input logic [5:0] b, input logic [5:0] d,
                       input logic aw, input logic aww, input logic [5:0] ad, input logic [15:0] adata,
                       input logic lw, input logic lww, input logic [5:0] ld, input logic [15:0] ldata);
    in_valid = 1'b1; in_op = op; in_a = a; in_word = w; in_b = b; in_d = d;
    set_wb(aw, aww, ad, adata);
    tick;
    in_valid = 1'b0;
    set_wb(lw, lww, ld, ldata);
    tick;
    set_wb(1'b0, 1'b0, 6'd0, 16'h0);
  endtask

  task automatic consume;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_word = 1'b0; in_b = '0; in_d = '0;
    out_ready = 1'b0;
    set_wb(1'b0, 1'b0, 6'd0, 16'h0);
    tick;
    // Preload while the stage is held in reset
    set_wb(1'b1, 1'b0, 6'd5,  16'h003C); tick;
    set_wb(1'b1, 1'b0, 6'd6,  16'h0011); tick;
    set_wb(1'b1, 1'b0, 6'd24, 16'h00AB); tick;
    set_wb(1'b1, 1'b0, 6'd25, 16'h00CD); tick;
    set_wb(1'b0, 1'b0, 6'd0, 16'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if ({out_op, out_d, out_Ra, out_Rb} !== 46'h0) begin errors++;
      $display("FAIL reset_outputs: got op=%h d=%h Ra=%h Rb=%h expected all 0", out_op, out_d, out_Ra, out_Rb); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    $display("reset: done");
  endtask

  task automatic test_basic;
    checks++; if (rf_a !== 6'd0) begin errors++; $display("FAIL rf_addr_idle: got %h expected 0", rf_a); end
    in_valid = 1'b1; in_op = 16'h1111; in_a = 6'd5; in_word = 1'b0; in_b = 6'd6; in_d = 6'd3;
    #1;
    checks++; if (rf_a !== 6'd5 || rf_b !== 6'd6) begin errors++; $display("FAIL rf_addr: got %h/%h expected 05/06", rf_a, rf_b); end
    tick;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL load_state: got valid=%b ready=%b expected 0/0", out_valid, in_ready); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    checks++; if (out_Ra !== 16'h003C || out_Rb !== 8'h11) begin errors++;
      $display("FAIL basic_operands: got Ra=%h Rb=%h expected 003c/11", out_Ra, out_Rb); end
    checks++; if (out_op !== 16'h1111 || out_d !== 6'd3) begin errors++;
      $display("FAIL basic_passthru: got op=%h d=%h expected 1111/03", out_op, out_d); end
    $display("basic: op=%h Ra=%h Rb=%h", out_op, out_Ra, out_Rb);
    consume;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_word;
    issue(16'h2222, 6'd24, 1'b1, 6'd5, 6'd1, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
    checks++; if (out_Ra !== 16'hCDAB || out_Rb !== 8'h3C) begin errors++;
      $display("FAIL word_even: got Ra=%h Rb=%h expected cdab/3c", out_Ra, out_Rb); end
    $display("word a=24: Ra=%h Rb=%h", out_Ra, out_Rb);
    consume;
    issue(16'h2223, 6'd25, 1'b1, 6'd24, 6'd2, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
    checks++; if (out_Ra !== 16'h00CD || out_Rb !== 8'hAB) begin errors++;
      $display("FAIL word_odd: got Ra=%h Rb=%h expected 00cd/ab", out_Ra, out_Rb); end
    $display("word a=25: Ra=%h Rb=%h", out_Ra, out_Rb);
    consume;
  endtask

  task automatic test_forward;
    logic [15:0] exp_a;
    logic [7:0]  exp_b;
    // accept-cycle byte write r5 <= 77
    issue(16'h3333, 6'd5, 1'b0, 6'd6, 6'd4, 1'b1, 1'b0, 6'd5, 16'hFF77, 1'b0, 1'b0, 6'd0, 16'h0);
    exp_a = FWD ? 16'h0077 : 16'h003C;
    checks++; if (out_Ra !== exp_a || out_Rb !== 8'h11) begin errors++;
      $display("FAIL fwd_accept: got Ra=%h Rb=%h expected %h/11", out_Ra, out_Rb, exp_a); end
    $display("fwd accept: Ra=%h", out_Ra);
    consume;
    // accept-cycle r5 <= 55 then LOAD-cycle r5 <= 66: newer wins
    issue(16'h3334, 6'd5, 1'b0, 6'd6, 6'd4, 1'b1, 1'b0, 6'd5, 16'h0055, 1'b1, 1'b0, 6'd5, 16'h0066);
    exp_a = FWD ? 16'h0066 : 16'h0077;
    checks++; if (out_Ra !== exp_a || out_Rb !== 8'h11) begin errors++;
      $display("FAIL fwd_priority: got Ra=%h Rb=%h expected %h/11", out_Ra, out_Rb, exp_a); end
    $display("fwd priority: Ra=%h", out_Ra);
    consume;
    // LOAD-cycle word write d=25 covers both A bytes and B
    issue(16'h3335, 6'd24, 1'b1, 6'd25, 6'd4, 1'b0, 1'b0, 6'd0, 16'h0, 1'b1, 1'b1, 6'd25, 16'hBEEF);
    exp_a = FWD ? 16'hBEEF : 16'hCDAB;
    exp_b = FWD ? 8'hBE : 8'hCD;
    checks++; if (out_Ra !== exp_a || out_Rb !== exp_b) begin errors++;
      $display("FAIL fwd_load_word: got Ra=%h Rb=%h expected %h/%h", out_Ra, out_Rb, exp_a, exp_b); end
    $display("fwd load word: Ra=%h Rb=%h", out_Ra, out_Rb);
    consume;
  endtask

  task automatic test_hold;
    logic [15:0] exp_a;
    issue(16'h4444, 6'd24, 1'b1, 6'd6, 6'd7, 1'b0, 1'b0, 6'd0, 16'h0, 1'b0, 1'b0, 6'd0, 16'h0);
    checks++; if (out_Ra !== 16'hBEEF) begin errors++; $display("FAIL hold_initial: got %h expected beef", out_Ra); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", in_ready); end
    set_wb(1'b1, 1'b1, 6'd24, 16'h1234);
    tick;
    set_wb(1'b0, 1'b0, 6'd0, 16'h0);
    exp_a = FWD ? 16'h1234 : 16'hBEEF;
    checks++; if (out_Ra !== exp_a || out_Rb !== 8'h11) begin errors++;
      $display("FAIL hold_update: got Ra=%h Rb=%h expected %h/11", out_Ra, out_Rb, exp_a); end
    tick; tick;
    checks++; if (out_valid !== 1'b1 || out_op !== 16'h4444 || out_Ra !== exp_a) begin errors++;
      $display("FAIL hold_stable: got valid=%b op=%h Ra=%h expected 1/4444/%h", out_valid, out_op, out_Ra, exp_a); end
    $display("hold: op=%h Ra=%h", out_op, out_Ra);
    consume;
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int recv = 0;
    logic acc;
    in_a = 6'd5; in_word = 1'b0; in_b = 6'd6; in_d = 6'd9;
    in_valid = 1'b1; out_ready = 1'b1; in_op = 16'hA000;
    #1;
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== (c > 0 && c % 2 == 0)) begin errors++;
        $display("FAIL b2b_valid c=%0d: got %b expected %b", c, out_valid, (c > 0 && c % 2 == 0)); end
      if (out_valid) begin
        checks++; if (out_op !== 16'hA000 + 16'(recv) || out_Ra !== 16'h0066) begin errors++;
          $display("FAIL b2b_data: got op=%h Ra=%h expected %h/0066", out_op, out_Ra, 16'hA000 + 16'(recv)); end
        $display("b2b: cycle %0d op=%h", c, out_op);
        recv++;
      end
      acc = in_valid && in_ready;
      tick;
      if (acc) sent++;
      in_op = 16'hA000 + 16'(sent);
    end
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    checks++; if (sent != 5 || recv != 4) begin errors++;
      $display("FAIL b2b_count: got sent=%0d recv=%0d expected 5/4", sent, recv); end
  endtask

  task automatic test_reset_load;
    in_valid = 1'b1; in_op = 16'h5555; in_a = 6'd5; in_word = 1'b0; in_b = 6'd6; in_d = 6'd2;
    tick;
    in_valid = 1'b0;
    reset = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0 || {out_op, out_d, out_Ra, out_Rb} !== 46'h0) begin errors++;
      $display("FAIL reset_load_outputs: got valid=%b op=%h d=%h Ra=%h Rb=%h expected all 0",
               out_valid, out_op, out_d, out_Ra, out_Rb); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", in_ready); end
    tick; tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_load_discard: got %b expected 0", out_valid); end
    $display("reset in LOAD: done");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_word;
    test_forward;
    test_hold;
    test_back_to_back;
    test_reset_load;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly upstream of the register file and downstream of instruction decode. Accepts a decoded instruction with source/destination register indices over a valid/ready handshake, drives the regfile read addresses, absorbs the regfile's one-cycle BRAM read latency, and presents the 16-bit A operand and 8-bit B operand to execute over a second valid/ready handshake. Writes landing from writeback are snooped and forwarded, so held or in-flight operands never go stale.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- in_valid  in  1  decode offers an instruction.
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready at a rising edge.
- in_op  in  16  opcode word; passed through unmodified.
- in_a  in  6  A source register index.
- in_word  in  1  A is a register pair (a, a+1).
- in_b  in  6  B source register index.
- in_d  in  6  destination index; passed through.
- rf_a, rf_b  out  6  regfile read addresses.
- rf_Ra  in  16  regfile A data, valid one cycle after address sampled.
- rf_Rb  in  8  regfile B data, same latency.
- wb_write, wb_word  in  1  writeback strobe / word write (same meaning as the regfile write port).
- wb_d  in  6  writeback destination index.
- wb_Rd  in  16  writeback data; byte writes use [7:0].
- out_valid  out  1  operands valid.
- out_ready  in  1  execute consumes; transfer when out_valid && out_ready.
- out_op  out  16; out_d  out  6; out_Ra  out  16; out_Rb  out  8.

## Operation
- States: IDLE, LOAD, HOLD.
- rf_a = in_a, rf_b = in_b combinationally at all times; the regfile samples them on the same edge as the accept.
- in_ready = reset && (IDLE || (HOLD && out_ready)); 0 in LOAD and while reset is low.
- Accept: latch in_op, in_d, a, b, word flag; -> LOAD. If in_word && in_a[0]=1, word flag is cleared (byte read).
- LOAD: rf data valid; at edge capture operands into out_Ra/out_Rb, -> HOLD.
- HOLD: out_valid=1. On out_ready: if in_valid also accepted -> LOAD, else -> IDLE. Without out_ready: stay, outputs stable except forwarding updates.
- Operand bytes: A low = reg a; A high = reg a+1 if word, else 8'h00; B = reg b.
- Forwarding, per byte, at byte granularity: byte write targets wb_d; word write targets wb_d&~1 (low, wb_Rd[7:0]) and wb_d|1 (high, wb_Rd[15:8]).
- A write in the accept cycle is registered and applied at LOAD capture (BRAM returns old data for same-edge read/write). A write during LOAD takes priority over the accept-cycle write; both over rf data.
- In HOLD, any matching write updates the held byte at the edge.
- Reset: state IDLE, out_valid 0, out_op/out_d/out_Ra/out_Rb all 0, forward registers cleared. Reset in LOAD/HOLD discards the instruction.

## Timing
- Accept at edge T -> LOAD during T+1 -> out_valid from T+2. Latency 2 cycles.
- Max throughput one instruction per 2 cycles (accept overlaps HOLD handoff).
- out_* change only at edges; no combinational path from in_* or wb_* to out_*.
- in_ready depends combinationally on out_ready in HOLD.

## Configuration
- OPFETCH_FWD_EN defined: forwarding as above.
- Undefined: wb_* ignored; operands come from rf_Ra/rf_Rb only and held values are never updated; decode must guarantee hazard spacing.

## Test plan
- r5=0x3C, r6=0x11 preloaded; accept a=5, b=6, word=0 -> out_valid at T+2, out_Ra=0x003C, out_Rb=0x11.
- r24=0xAB, r25=0xCD; a=24, word=1 -> out_Ra=0xCDAB; a=25, word=1 -> word cleared, out_Ra=0x00CD.
- Byte write r5<=0x77 on the accept edge, a=5 -> out_Ra=0x0077 (forward path; with macro undefined -> stale 0x003C).
- out_ready held low 3 cycles in HOLD, word write d=24 Rd=0x1234 during hold, a=24 word -> out_Ra becomes 0x1234 next edge, out_op unchanged.
- Back-to-back: in_valid constant, out_ready=1 -> accepts every 2 cycles, out_valid pulses on alternating cycles, ops in order.
- reset low for one cycle during LOAD -> next cycle out_valid=0, all outputs 0, in_ready=1 after release.
